cfg_write_arbiter: RTL
======================

Name: cfg_write_arbiter

Overview:
- Sits in the system clock domain between two configuration masters and the SDR control outputs.
- Master 0 is the synchronised RP2040 SPI command stream; master 1 is the Ethernet control path.
- Round-robin arbitrates read/write transactions into one register bank and double-buffers all writes in shadow registers.
- Shadow values move to active outputs atomically on a commit, so NCO, gain and filter settings change together.

Parameters:
- DATA_WIDTH, 32, register data width (fixed; not intended to be changed).
- FREQ_DEFAULT, 32'h40000000, reset value of the frequency word.
- GAIN_DEFAULT, 8'h80, reset value of the gain.
- BW_DEFAULT, 8'd80, reset value of the bandwidth limit.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
m0_req_valid  in  1  master 0 request valid
m0_req_ready  out  1  master 0 request accepted (combinational)
m0_req_we  in  1  1=write, 0=read
m0_req_addr  in  8  register address
m0_req_wdata  in  32  write data
m0_rsp_valid  out  1  response valid
m0_rsp_ready  in  1  response consumed
m0_rsp_rdata  out  32  read data (0 for writes/errors)
m0_rsp_err  out  1  bad address or illegal write
m1_*  same set as m0_*  master 1 (Ethernet)
status_reg  in  16  system status
pll_locked  in  1  PLL lock
eth_link_status  in  1  Ethernet link
frequency_word  out  32  active NCO word
gain_control  out  8  active gain
filter_select  out  4  active filter
enable_control  out  1  active enable
streaming_mode  out  1  active streaming mode
bandwidth_limit  out  8  active bandwidth limit
cfg_update  out  1  one-cycle pulse when active registers change
shadow_dirty  out  1  shadow differs from active (set by any successful write, cleared by commit)

Behaviour:
- Register map:
  - 0x00 freq[31:0], 0x01 gain[7:0], 0x02 filter[3:0], 0x03 enable[0], 0x04 stream[0], 0x05 bw[7:0]. All are R/W; writes go to shadow, reads return active, zero-extended.
  - 0x06 COMMIT: a write with wdata[0]=1 commits; wdata[0]=0 is a no-op with no error. A read returns {31'd0, shadow_dirty}.
  - 0x10 STATUS: read-only, returns {14'd0, eth_link_status, pll_locked, status_reg}.
  - Any other address, or a write to 0x10, gives rsp_err=1, rdata=0, and no state change.
- FSM states ARB, EXEC, RESP.
- ARB:
  - If exactly one req_valid is high, grant that master.
  - If both are high, grant the master named by rr_ptr.
  - The granted master's req_ready is high in the same cycle. The other master's ready stays low. Capture we/addr/wdata, go to EXEC.
  - rr_ptr is set to the non-granted index on every grant.
  - ready is never high outside ARB.
- EXEC (1 cycle):
  - Decode, update shadow, or perform the commit.
  - Compute rdata/err, go to RESP.
- Commit (in EXEC):
  - Copies all six shadow fields to active in that cycle.
  - cfg_update pulses high for exactly the next cycle (first RESP cycle); shadow_dirty clears.
  - A commit with shadow_dirty=0 still pulses cfg_update.
- RESP:
  - The granted master's rsp_valid is held high with stable rdata/err until rsp_ready is high; that cycle returns to ARB.
  - The other master's rsp_valid is always 0.
- Latency: request accept to rsp_valid is 2 cycles. Minimum transaction is 3 cycles.
- Reads of active registers after a write but before commit return the old active value.
- Reset (any state, including mid-RESP):
  - State goes to ARB, rr_ptr=0. All rsp_valid, req_ready and cfg_update are 0.
  - Shadow and active take defaults: freq FREQ_DEFAULT, gain GAIN_DEFAULT, filter 0, enable 0, stream 0, bw BW_DEFAULT. shadow_dirty=0.
  - rsp_rdata=0, rsp_err=0.

Optional Feature:
- CFG_ERR_COUNT_EN defined:
  - Adds a 16-bit saturating error counter, incremented in EXEC on each rsp_err, stopping at 0xFFFF.
  - Readable at 0x11 as {16'd0, count}. A write to 0x11 of any value clears it with no error. Reset clears it.
- Undefined: 0x11 is an unmapped address (err=1), and no counter logic exists.

Test Plan:
- Reset, then read 0x00 from m0 -> rsp_rdata=32'h40000000, err=0; read 0x05 -> 32'd80; cfg_update never pulses.
- m0 write 0x01=0x3C, then read 0x01 -> 0x80, shadow_dirty=1. Write 0x06=1 -> cfg_update one cycle, gain_control=0x3C, shadow_dirty=0.
- Both masters hold valid continuously after reset -> grants alternate m0, m1, m0, m1; each rsp_valid appears exactly 2 cycles after its ready.
- m1 write 0x10, and m1 read 0x7F -> both rsp_err=1, rdata=0, outputs unchanged. With CFG_ERR_COUNT_EN, read 0x11 -> 2.
- Hold m0_rsp_ready low for 5 cycles -> rsp_valid and rdata stable, m1 not granted; release -> m1 granted next ARB cycle.
- Assert rst during RESP after a committed freq write of 0x12345678 -> next cycle rsp_valid=0 and frequency_word=32'h40000000.

Source files
------------

// File: rtl/cfg_write_arbiter.sv
// Two-master round-robin configuration register bank with shadow/active double buffering.
// Optional CFG_ERR_COUNT_EN adds a saturating error counter readable/clearable at 0x11.
module cfg_write_arbiter #(
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] FREQ_DEFAULT = 32'h40000000,
  parameter logic [7:0]  GAIN_DEFAULT = 8'h80,
  parameter logic [7:0]  BW_DEFAULT   = 8'd80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_req_we,
  input  logic [7:0]            m0_req_addr,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  output logic                  m0_rsp_valid,
  input  logic                  m0_rsp_ready,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  output logic                  m0_rsp_err,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_req_we,
  input  logic [7:0]            m1_req_addr,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  output logic                  m1_rsp_valid,
  input  logic                  m1_rsp_ready,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
  output logic                  m1_rsp_err,
  input  logic [15:0]           status_reg,
  input  logic                  pll_locked,
  input  logic                  eth_link_status,
  output logic [31:0]           frequency_word,
  output logic [7:0]            gain_control,
  output logic [3:0]            filter_select,
  output logic                  enable_control,
  output logic                  streaming_mode,
  output logic [7:0]            bandwidth_limit,
  output logic                  cfg_update,
  output logic                  shadow_dirty
);

  typedef enum logic [1:0] {ARB, EXEC, RESP} state_t;

  typedef struct packed {
    logic [31:0] freq;
    logic [7:0]  gain;
    logic [3:0]  filt;
    logic        en;
    logic        strm;
    logic [7:0]  bw;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{freq: FREQ_DEFAULT, gain: GAIN_DEFAULT, filt: 4'd0,
                                 en: 1'b0, strm: 1'b0, bw: BW_DEFAULT};

  state_t                state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  gnt_q, gnt_d;
  logic                  we_q, we_d;
  logic [7:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  upd_q, upd_d;
  cfg_t                  shadow_q, shadow_d;
  cfg_t                  active_q, active_d;
  logic                  dirty_q, dirty_d;
  logic                  arb_sel;
`ifdef CFG_ERR_COUNT_EN
  logic [15:0]           errcnt_q, errcnt_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB;
      rr_q     <= 1'b0;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      upd_q    <= 1'b0;
      shadow_q <= CFG_RESET;
      active_q <= CFG_RESET;
      dirty_q  <= 1'b0;
`ifdef CFG_ERR_COUNT_EN
      errcnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      upd_q    <= upd_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      dirty_q  <= dirty_d;
`ifdef CFG_ERR_COUNT_EN
      errcnt_q <= errcnt_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    upd_d        = 1'b0;
    shadow_d     = shadow_q;
    active_d     = active_q;
    dirty_d      = dirty_q;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
`ifdef CFG_ERR_COUNT_EN
    errcnt_d     = errcnt_q;
`endif
    // A lone requester always wins; rr_q only breaks ties
    arb_sel = rr_q;
    if (m0_req_valid && !m1_req_valid) arb_sel = 1'b0;
    else if (m1_req_valid && !m0_req_valid) arb_sel = 1'b1;

    case (state_q)
      ARB: begin
        if (m0_req_valid || m1_req_valid) begin
          m0_req_ready = !arb_sel;
          m1_req_ready = arb_sel;
          gnt_d        = arb_sel;
          rr_d         = !arb_sel;
          we_d         = arb_sel ? m1_req_we    : m0_req_we;
          addr_d       = arb_sel ? m1_req_addr  : m0_req_addr;
          wdata_d      = arb_sel ? m1_req_wdata : m0_req_wdata;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rdata_d = '0;
        err_d   = 1'b0;
        case (addr_q)
          8'h00: if (we_q) begin shadow_d.freq = wdata_q;      dirty_d = 1'b1; end
                 else rdata_d = active_q.freq;
          8'h01: if (we_q) begin shadow_d.gain = wdata_q[7:0]; dirty_d = 1'b1; end
                 else rdata_d = {24'd0, active_q.gain};
          8'h02: if (we_q) begin shadow_d.filt = wdata_q[3:0]; dirty_d = 1'b1; end
                 else rdata_d = {28'd0, active_q.filt};
          8'h03: if (we_q) begin shadow_d.en   = wdata_q[0];   dirty_d = 1'b1; end
                 else rdata_d = {31'd0, active_q.en};
          8'h04: if (we_q) begin shadow_d.strm = wdata_q[0];   dirty_d = 1'b1; end
                 else rdata_d = {31'd0, active_q.strm};
          8'h05: if (we_q) begin shadow_d.bw   = wdata_q[7:0]; dirty_d = 1'b1; end
                 else rdata_d = {24'd0, active_q.bw};
          // Commit moves every field at once so NCO, gain and filter change together
          8'h06: if (we_q) begin
                   if (wdata_q[0]) begin
                     active_d = shadow_q;
                     dirty_d  = 1'b0;
                     upd_d    = 1'b1;
                   end
                 end else rdata_d = {31'd0, dirty_q};
          8'h10: if (we_q) err_d = 1'b1;
                 else rdata_d = {14'd0, eth_link_status, pll_locked, status_reg};
`ifdef CFG_ERR_COUNT_EN
          8'h11: if (we_q) errcnt_d = '0;
                 else rdata_d = {16'd0, errcnt_q};
`endif
          default: err_d = 1'b1;
        endcase
`ifdef CFG_ERR_COUNT_EN
        if (err_d && errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
`endif
        state_d = RESP;
      end
      RESP: begin
        if (gnt_q ? m1_rsp_ready : m0_rsp_ready) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  assign m0_rsp_valid = (state_q == RESP) && !gnt_q;
  assign m1_rsp_valid = (state_q == RESP) && gnt_q;
  assign m0_rsp_rdata = m0_rsp_valid ? rdata_q : '0;
  assign m1_rsp_rdata = m1_rsp_valid ? rdata_q : '0;
  assign m0_rsp_err   = m0_rsp_valid && err_q;
  assign m1_rsp_err   = m1_rsp_valid && err_q;

  assign frequency_word  = active_q.freq;
  assign gain_control    = active_q.gain;
  assign filter_select   = active_q.filt;
  assign enable_control  = active_q.en;
  assign streaming_mode  = active_q.strm;
  assign bandwidth_limit = active_q.bw;
  assign cfg_update      = upd_q;
  assign shadow_dirty    = dirty_q;

endmodule
